// File: rtl/class_train_sched.sv
// Training scheduler for an HDC class generator: buffers encoded samples, sequences
// one bundle per sample, then requests binarization once the dataset's last sample is done.
module class_train_sched #(
  parameter int HV_DIM          = 5000,
  parameter int SEQ_CYCLE_COUNT = 10,
  parameter int NUM_CLASSES     = 26,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              soft_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] in_hv,
  input  logic [4:0]        in_label,
  input  logic              in_last,
  output logic [HV_DIM-1:0] encoded_hv,
  output logic [4:0]        class_select_bits,
  output logic              training_hdc_model,
  output logic              start_class_gen,
  output logic              training_dataset_finished,
  input  logic              class_gen_done,
  output logic              busy,
  output logic              train_done,
  output logic              err_label
);

  typedef enum logic [2:0] {IDLE, START, BUNDLE, FINISH, WAIT_DONE, DONE} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SEQ_W = $clog2(SEQ_CYCLE_COUNT + 1);

  state_t                 state;
  logic [HV_DIM-1:0]      mem_hv    [FIFO_DEPTH];
  logic [4:0]             mem_label [FIFO_DEPTH];
  logic                   mem_last  [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [NUM_CLASSES-1:0] seen;
  logic [SEQ_W-1:0]       seq_cnt;
  logic                   held_last;
  logic                   last_accepted;

  logic                   fifo_full, fifo_empty, push, pop, head_label_ok;
  logic [4:0]             head_label;
  logic [NUM_CLASSES-1:0] head_mask, sel_mask;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_count == '0);
  assign head_label    = mem_label[rd_ptr];
  assign head_label_ok = (int'(head_label) < NUM_CLASSES);
  assign head_mask     = NUM_CLASSES'(1) << head_label;
  assign sel_mask      = NUM_CLASSES'(1) << class_select_bits;

  // Clear wins over a new sample, and a full FIFO never accepts even if it pops this cycle.
  assign in_ready = !nrst && en && !soft_clear && !fifo_full
                    && (state != DONE) && !last_accepted;
  assign push     = in_valid && in_ready;
  assign pop      = en && !soft_clear && (state == IDLE) && !fifo_empty;
  assign busy     = (state != IDLE) || !fifo_empty;

  // NOTE: FIFO storage has no reset; pointers and the count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_hv[wr_ptr]    <= in_hv;
      mem_label[wr_ptr] <= in_label;
      mem_last[wr_ptr]  <= in_last;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state                     <= IDLE;
      wr_ptr                    <= '0;
      rd_ptr                    <= '0;
      fifo_count                <= '0;
      seen                      <= '0;
      seq_cnt                   <= '0;
      held_last                 <= 1'b0;
      last_accepted             <= 1'b0;
      encoded_hv                <= '0;
      class_select_bits         <= '0;
      training_hdc_model        <= 1'b0;
      start_class_gen           <= 1'b0;
      training_dataset_finished <= 1'b0;
      train_done                <= 1'b0;
      err_label                 <= 1'b0;
    end else if (en) begin
      start_class_gen           <= 1'b0;
      training_dataset_finished <= 1'b0;
      err_label                 <= 1'b0;
      if (soft_clear) begin
        state              <= IDLE;
        wr_ptr             <= '0;
        rd_ptr             <= '0;
        fifo_count         <= '0;
        seen               <= '0;
        seq_cnt            <= '0;
        held_last          <= 1'b0;
        last_accepted      <= 1'b0;
        encoded_hv         <= '0;
        class_select_bits  <= '0;
        training_hdc_model <= 1'b0;
        train_done         <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= ptr_next(wr_ptr);
          if (in_last) last_accepted <= 1'b1;
        end
        if (pop) rd_ptr <= ptr_next(rd_ptr);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);

        case (state)
          IDLE: begin
            if (pop) begin
              if (head_label_ok) begin
                encoded_hv         <= mem_hv[rd_ptr];
                class_select_bits  <= head_label;
                training_hdc_model <= |(seen & head_mask);
                held_last          <= mem_last[rd_ptr];
                start_class_gen    <= 1'b1;
                state              <= START;
              end else begin
                // Out-of-range label: drop it, but still honour its last flag.
                err_label <= 1'b1;
                if (mem_last[rd_ptr]) begin
                  training_dataset_finished <= 1'b1;
                  state                     <= FINISH;
                end
              end
            end
          end
          START: begin
            seen    <= seen | sel_mask;
            seq_cnt <= '0;
            state   <= BUNDLE;
          end
          BUNDLE: begin
            seq_cnt <= seq_cnt + 1'b1;
            if (seq_cnt == SEQ_W'(SEQ_CYCLE_COUNT - 1)) begin
              if (held_last) begin
                training_dataset_finished <= 1'b1;
                state                     <= FINISH;
              end else begin
                state <= IDLE;
              end
            end
          end
          FINISH: state <= WAIT_DONE;
          WAIT_DONE: begin
            if (class_gen_done) begin
              train_done <= 1'b1;
              state      <= DONE;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
